// File: rtl/rollback_pkg.sv
// rtl/rollback_pkg.sv - shared types and helpers for the rollback arbiter
package rollback_pkg;

  localparam int STRAND_FIELD_W = 8;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HOLD = 2'd1,
    SUSP = 2'd2
  } strand_state_t;

  // Strand is carried zero-extended so the struct width does not depend on NUM_STRANDS.
  typedef struct packed {
    logic                      valid;
    logic [STRAND_FIELD_W-1:0] strand;
    logic [31:0]               pc;
    logic [3:0]                lane;
    logic                      retry;
    logic                      suspend;
  } rollback_req_t;

  function automatic int siw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/strand_rollback_state.sv
// rtl/strand_rollback_state.sv - per-strand RUN/HOLD/SUSP state, holdoff and retry counters
module strand_rollback_state
  import rollback_pkg::*;
#(
  parameter int HOLDOFF_CYCLES = 2,
  parameter int RETRY_LIMIT    = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic win_i,
  input  logic win_retry_i,
  input  logic win_suspend_i,
  input  logic wake_i,
  output logic blocked_o,
  output logic livelock_o
);

  localparam logic [3:0] HOLD_LOAD = 4'(HOLDOFF_CYCLES);
  localparam logic [7:0] RETRY_LIM = 8'(RETRY_LIMIT);

  strand_state_t state_q, state_d;
  logic [3:0]    hold_q, hold_d;
  logic [7:0]    retry_q, retry_d;
  logic          livelock_q, livelock_d;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      RUN: begin
        if (win_i) begin
          if (win_suspend_i) begin
            state_d = SUSP;
          end else begin
            state_d = HOLD;
            hold_d  = HOLD_LOAD;
          end
        end
      end
      HOLD: begin
        if (win_i) begin
          if (win_suspend_i) state_d = SUSP;
          else               hold_d  = HOLD_LOAD;
        end else if (hold_q <= 4'd1) begin
          state_d = RUN;
        end else begin
          hold_d = hold_q - 4'd1;
        end
      end
      SUSP: begin
        // A suspending winner beats a same-cycle wake.
        if (!(win_i && win_suspend_i) && wake_i) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    retry_d = retry_q;
    if (win_i) begin
      if (win_retry_i) retry_d = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
      else             retry_d = 8'd0;
    end else if (wake_i) begin
      retry_d = 8'd0;
    end
    livelock_d = livelock_q | (retry_d >= RETRY_LIM);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= RUN;
      hold_q     <= 4'd0;
      retry_q    <= 8'd0;
      livelock_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      retry_q    <= retry_d;
      livelock_q <= livelock_d;
    end
  end

  assign blocked_o  = (state_q != RUN);
  assign livelock_o = livelock_q;

endmodule

// File: rtl/rollback_arbiter.sv
// rtl/rollback_arbiter.sv - oldest-request-per-strand rollback select, squash and registered outcome
module rollback_arbiter
  import rollback_pkg::*;
#(
  parameter int                       NUM_STRANDS    = 4,
  parameter int                       NUM_SOURCES    = 2,
  parameter int                       NUM_STAGES     = 6,
  parameter logic [NUM_SOURCES*8-1:0] SOURCE_STAGE   = {8'd5, 8'd1},
  parameter int                       HOLDOFF_CYCLES = 2,
  parameter int                       RETRY_LIMIT    = 8,
  localparam int                      SIW            = siw(NUM_STRANDS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SOURCES-1:0]     rq_valid,
  input  logic [NUM_SOURCES*SIW-1:0] rq_strand,
  input  logic [NUM_SOURCES*32-1:0]  rq_pc,
  input  logic [NUM_SOURCES*4-1:0]   rq_reg_lane,
  input  logic [NUM_SOURCES-1:0]     rq_retry,
  input  logic [NUM_SOURCES-1:0]     rq_suspend,
  input  logic [NUM_STAGES-1:0]      stage_valid,
  input  logic [NUM_STAGES*SIW-1:0]  stage_strand,
  input  logic [NUM_STRANDS-1:0]     wake_strand,
  output logic [NUM_STAGES-1:0]      rb_squash,
  output logic [NUM_STRANDS-1:0]     rb_rollback_strand,
  output logic [NUM_STRANDS*32-1:0]  rb_rollback_pc,
  output logic [NUM_STRANDS*4-1:0]   rb_rollback_reg_lane,
  output logic [NUM_STRANDS-1:0]     rb_retry_strand,
  output logic [NUM_STRANDS-1:0]     rb_strand_blocked,
  output logic [NUM_STRANDS-1:0]     rb_livelock
);

  rollback_req_t              req [NUM_SOURCES];
  logic [NUM_SOURCES-1:0]     src_win;
  logic [NUM_STRANDS-1:0]     win_valid;
  logic [NUM_STRANDS-1:0]     win_retry;
  logic [NUM_STRANDS-1:0]     win_suspend;
  logic [31:0]                pc_q   [NUM_STRANDS];
  logic [31:0]                pc_d   [NUM_STRANDS];
  logic [3:0]                 lane_q [NUM_STRANDS];
  logic [3:0]                 lane_d [NUM_STRANDS];
  logic [NUM_STRANDS-1:0]     strobe_q;
  logic [NUM_STRANDS-1:0]     retry_q;

  always_comb begin
    for (int i = 0; i < NUM_SOURCES; i++) begin
      req[i].valid   = rq_valid[i];
      req[i].strand  = STRAND_FIELD_W'(rq_strand[i*SIW +: SIW]);
      req[i].pc      = rq_pc[i*32 +: 32];
      req[i].lane    = rq_reg_lane[i*4 +: 4];
      req[i].retry   = rq_retry[i];
      req[i].suspend = rq_suspend[i];
    end
  end

  // Higher source index is older, so any older same-strand request knocks a source out.
  always_comb begin
    for (int i = 0; i < NUM_SOURCES; i++) begin
      src_win[i] = req[i].valid;
      for (int j = i + 1; j < NUM_SOURCES; j++) begin
        if (req[j].valid && (req[j].strand == req[i].strand)) src_win[i] = 1'b0;
      end
    end
  end

  always_comb begin
    for (int s = 0; s < NUM_STRANDS; s++) begin
      win_valid[s]   = 1'b0;
      win_retry[s]   = 1'b0;
      win_suspend[s] = 1'b0;
      pc_d[s]        = pc_q[s];
      lane_d[s]      = lane_q[s];
      for (int i = 0; i < NUM_SOURCES; i++) begin
        if (src_win[i] && (req[i].strand == STRAND_FIELD_W'(s))) begin
          win_valid[s]   = 1'b1;
          win_retry[s]   = req[i].retry;
          win_suspend[s] = req[i].suspend;
          pc_d[s]        = req[i].pc;
          lane_d[s]      = req[i].lane;
        end
      end
    end
  end

  // Only stages younger than the requesting stage are squashed.
  always_comb begin
    rb_squash = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      for (int i = 0; i < NUM_SOURCES; i++) begin
        if (src_win[i] && stage_valid[k] &&
            (STRAND_FIELD_W'(stage_strand[k*SIW +: SIW]) == req[i].strand) &&
            (k < int'(SOURCE_STAGE[i*8 +: 8]))) begin
          rb_squash[k] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      strobe_q <= '0;
      retry_q  <= '0;
      for (int s = 0; s < NUM_STRANDS; s++) begin
        pc_q[s]   <= 32'd0;
        lane_q[s] <= 4'd0;
      end
    end else begin
      strobe_q <= win_valid;
      retry_q  <= win_valid & win_retry;
      for (int s = 0; s < NUM_STRANDS; s++) begin
        pc_q[s]   <= pc_d[s];
        lane_q[s] <= lane_d[s];
      end
    end
  end

  for (genvar s = 0; s < NUM_STRANDS; s++) begin : g_strand
    strand_rollback_state #(
      .HOLDOFF_CYCLES (HOLDOFF_CYCLES),
      .RETRY_LIMIT    (RETRY_LIMIT)
    ) u_state (
      .clk           (clk),
      .reset         (reset),
      .win_i         (win_valid[s]),
      .win_retry_i   (win_retry[s]),
      .win_suspend_i (win_suspend[s]),
      .wake_i        (wake_strand[s]),
      .blocked_o     (rb_strand_blocked[s]),
      .livelock_o    (rb_livelock[s])
    );

    assign rb_rollback_pc[s*32 +: 32]      = pc_q[s];
    assign rb_rollback_reg_lane[s*4 +: 4]  = lane_q[s];
  end

  assign rb_rollback_strand = strobe_q;
  assign rb_retry_strand    = retry_q;

endmodule

// File: tb/tb_rollback_arbiter.sv
// tb/tb_rollback_arbiter.sv - directed scoreboard bench for rollback_arbiter
module tb_rollback_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   rq_valid;
  logic [3:0]   rq_strand;
  logic [63:0]  rq_pc;
  logic [7:0]   rq_reg_lane;
  logic [1:0]   rq_retry;
  logic [1:0]   rq_suspend;
  logic [5:0]   stage_valid;
  logic [11:0]  stage_strand;
  logic [3:0]   wake_strand;
  logic [5:0]   rb_squash;
  logic [3:0]   rb_rollback_strand;
  logic [127:0] rb_rollback_pc;
  logic [15:0]  rb_rollback_reg_lane;
  logic [3:0]   rb_retry_strand;
  logic [3:0]   rb_strand_blocked;
  logic [3:0]   rb_livelock;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [3:0] strobe;
    logic [3:0] retry;
    logic [3:0] blocked;
    logic [3:0] livelock;
  } exp_t;

  exp_t sb[$];

  rollback_arbiter dut (
    .clk                  (clk),
    .reset                (reset),
    .rq_valid             (rq_valid),
    .rq_strand            (rq_strand),
    .rq_pc                (rq_pc),
    .rq_reg_lane          (rq_reg_lane),
    .rq_retry             (rq_retry),
    .rq_suspend           (rq_suspend),
    .stage_valid          (stage_valid),
    .stage_strand         (stage_strand),
    .wake_strand          (wake_strand),
    .rb_squash            (rb_squash),
    .rb_rollback_strand   (rb_rollback_strand),
    .rb_rollback_pc       (rb_rollback_pc),
    .rb_rollback_reg_lane (rb_rollback_reg_lane),
    .rb_retry_strand      (rb_retry_strand),
    .rb_strand_blocked    (rb_strand_blocked),
    .rb_livelock          (rb_livelock)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    rq_valid     = '0;
    rq_strand    = '0;
    rq_pc        = '0;
    rq_reg_lane  = '0;
    rq_retry     = '0;
    rq_suspend   = '0;
    stage_valid  = '0;
    stage_strand = '0;
    wake_strand  = '0;
  endtask

  task automatic drive_req(input int src, input logic [1:0] strand, input logic [31:0] pc,
                           input logic [3:0] lane, input logic retry, input logic susp);
    rq_valid[src]           = 1'b1;
    rq_strand[src*2 +: 2]   = strand;
    rq_pc[src*32 +: 32]     = pc;
    rq_reg_lane[src*4 +: 4] = lane;
    rq_retry[src]           = retry;
    rq_suspend[src]         = susp;
  endtask

  task automatic expect_step(input string tag, input logic [3:0] st, input logic [3:0] rt,
                             input logic [3:0] bl, input logic [3:0] ll);
    exp_t e;
    e.tag = tag; e.strobe = st; e.retry = rt; e.blocked = bl; e.livelock = ll;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, "_strobe"},   128'(rb_rollback_strand), 128'(e.strobe));
    check({e.tag, "_retry"},    128'(rb_retry_strand),    128'(e.retry));
    check({e.tag, "_blocked"},  128'(rb_strand_blocked),  128'(e.blocked));
    check({e.tag, "_livelock"}, 128'(rb_livelock),        128'(e.livelock));
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_strobe",   128'(rb_rollback_strand),   128'(0));
    check("reset_blocked",  128'(rb_strand_blocked),    128'(0));
    check("reset_livelock", 128'(rb_livelock),          128'(0));
    check("reset_pc",       rb_rollback_pc,             128'(0));
    check("reset_lane",     128'(rb_rollback_reg_lane), 128'(0));
    reset = 1'b1;

    // Single young request: only stage 0 is younger than source 0.
    drive_req(0, 2'd2, 32'h100, 4'h3, 1'b0, 1'b0);
    stage_valid = 6'b001001;
    stage_strand[0*2 +: 2] = 2'd2;
    stage_strand[3*2 +: 2] = 2'd2;
    #1;
    check("t1_squash", 128'(rb_squash), 128'(6'b000001));
    expect_step("t1_rb", 4'b0100, 4'b0000, 4'b0100, 4'b0000);
    check("t1_pc2",   128'(rb_rollback_pc[2*32 +: 32]),      128'(32'h100));
    check("t1_lane2", 128'(rb_rollback_reg_lane[2*4 +: 4]), 128'(4'h3));
    idle_inputs();
    expect_step("t1_hold2", 4'b0000, 4'b0000, 4'b0100, 4'b0000);
    expect_step("t1_run",   4'b0000, 4'b0000, 4'b0000, 4'b0000);
    check("t1_pc2_hold", 128'(rb_rollback_pc[2*32 +: 32]), 128'(32'h100));

    // Two sources on strand 1: the older source 1 wins and squashes below stage 5.
    drive_req(0, 2'd1, 32'h40, 4'h1, 1'b0, 1'b0);
    drive_req(1, 2'd1, 32'h80, 4'h2, 1'b0, 1'b0);
    stage_valid = 6'b110001;
    stage_strand[0*2 +: 2] = 2'd1;
    stage_strand[4*2 +: 2] = 2'd1;
    stage_strand[5*2 +: 2] = 2'd1;
    #1;
    check("t2_squash", 128'(rb_squash), 128'(6'b010001));
    expect_step("t2_rb", 4'b0010, 4'b0000, 4'b0010, 4'b0000);
    check("t2_pc1",   128'(rb_rollback_pc[1*32 +: 32]),      128'(32'h80));
    check("t2_lane1", 128'(rb_rollback_reg_lane[1*4 +: 4]), 128'(4'h2));
    idle_inputs();
    expect_step("t5_hold2", 4'b0000, 4'b0000, 4'b0010, 4'b0000);
    drive_req(0, 2'd1, 32'h44, 4'h5, 1'b0, 1'b0);
    expect_step("t5_reload", 4'b0010, 4'b0000, 4'b0010, 4'b0000);
    check("t5_pc1", 128'(rb_rollback_pc[1*32 +: 32]), 128'(32'h44));
    idle_inputs();
    expect_step("t5_more1", 4'b0000, 4'b0000, 4'b0010, 4'b0000);
    expect_step("t5_run",   4'b0000, 4'b0000, 4'b0000, 4'b0000);
    check("t5_pc2_kept", 128'(rb_rollback_pc[2*32 +: 32]), 128'(32'h100));

    // Suspend until wake; a suspending winner beats a same-cycle wake.
    drive_req(1, 2'd3, 32'h300, 4'h0, 1'b0, 1'b1);
    expect_step("t3_susp", 4'b1000, 4'b0000, 4'b1000, 4'b0000);
    idle_inputs();
    for (int n = 0; n < 20; n++) expect_step($sformatf("t3_idle%0d", n), 4'b0000, 4'b0000, 4'b1000, 4'b0000);
    drive_req(1, 2'd3, 32'h304, 4'h0, 1'b0, 1'b1);
    wake_strand = 4'b1000;
    expect_step("t3_wake_vs_susp", 4'b1000, 4'b0000, 4'b1000, 4'b0000);
    idle_inputs();
    wake_strand = 4'b1000;
    expect_step("t3_wake", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    idle_inputs();

    // Eight consecutive retries raise livelock; it survives a non-retry rollback.
    for (int n = 1; n <= 8; n++) begin
      idle_inputs();
      drive_req(0, 2'd0, 32'h10 + 32'(n), 4'h0, 1'b1, 1'b0);
      expect_step($sformatf("t4_retry%0d", n), 4'b0001, 4'b0001, 4'b0001,
                  (n == 8) ? 4'b0001 : 4'b0000);
    end
    idle_inputs();
    drive_req(0, 2'd0, 32'h20, 4'h0, 1'b0, 1'b0);
    expect_step("t4_clear", 4'b0001, 4'b0000, 4'b0001, 4'b0001);
    idle_inputs();
    expect_step("t4_hold2", 4'b0000, 4'b0000, 4'b0001, 4'b0001);
    expect_step("t4_run",   4'b0000, 4'b0000, 4'b0000, 4'b0001);

    // Suspended strand with a retry count of 5, then reset with a concurrent request.
    for (int n = 1; n <= 5; n++) begin
      idle_inputs();
      drive_req(0, 2'd2, 32'h200, 4'h7, 1'b1, 1'b1);
      expect_step($sformatf("t6_susp%0d", n), 4'b0100, 4'b0100, 4'b0100, 4'b0001);
    end
    idle_inputs();
    drive_req(1, 2'd1, 32'h99, 4'h9, 1'b1, 1'b0);
    reset = 1'b0;
    expect_step("t6_reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    check("t6_pc",   rb_rollback_pc,             128'(0));
    check("t6_lane", 128'(rb_rollback_reg_lane), 128'(0));
    reset = 1'b1;
    idle_inputs();
    expect_step("t6_after", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    check("sb_drained", 128'(sb.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rollback_arbiter.md
Name: rollback_arbiter

Overview:
- Parametrised successor to the per-core rollback reconciler.
- Accepts rollback requests from NUM_SOURCES pipeline stages for NUM_STRANDS strands and selects the oldest request per strand.
- Squashes younger same-strand instructions in NUM_STAGES tracked stages, and registers the rollback/retry/suspend outcome to fetch and strand select.
- Adds per-strand state the old block lacks: post-rollback holdoff, suspend-until-wake, and a saturating retry counter with livelock flag.

Parameters:
NUM_STRANDS, 4, strands per core (power of two, ≥2); SIW = $clog2(NUM_STRANDS)
NUM_SOURCES, 2, rollback-requesting stages; index order = age order, higher index = older
NUM_STAGES, 6, tracked squashable stages; index 0 = youngest (decode)
SOURCE_STAGE, {8'd5,8'd1}, packed NUM_SOURCES×8: source i squashes stages with index < SOURCE_STAGE[i]
HOLDOFF_CYCLES, 2, cycles a strand stays blocked after a non-suspend rollback (1..15)
RETRY_LIMIT, 8, consecutive retries before livelock flag (1..255)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
rq_valid  in  NUM_SOURCES  rollback request per source
rq_strand  in  NUM_SOURCES*SIW  requesting strand
rq_pc  in  NUM_SOURCES*32  restart PC
rq_reg_lane  in  NUM_SOURCES*4  restart vector lane
rq_retry  in  NUM_SOURCES  request is a cache-miss retry
rq_suspend  in  NUM_SOURCES  strand must suspend
stage_valid  in  NUM_STAGES  stage holds a live instruction
stage_strand  in  NUM_STAGES*SIW  strand in each stage
wake_strand  in  NUM_STRANDS  releases a suspended strand
rb_squash  out  NUM_STAGES  squash per stage (combinational)
rb_rollback_strand  out  NUM_STRANDS  registered rollback strobe
rb_rollback_pc  out  NUM_STRANDS*32  registered PC
rb_rollback_reg_lane  out  NUM_STRANDS*4  registered lane
rb_retry_strand  out  NUM_STRANDS  registered retry strobe
rb_strand_blocked  out  NUM_STRANDS  strand not eligible for issue
rb_livelock  out  NUM_STRANDS  sticky retry-limit flag

Behaviour:
- Per strand s, the winner is the highest-index source i with rq_valid[i] && rq_strand[i]==s. Lower-index requests for s are discarded that cycle.
- rb_squash[k] = OR over winners i of (stage_valid[k] && stage_strand[k]==winner strand && k < SOURCE_STAGE[i]). Same-cycle, no latency. The requesting stage itself is never squashed.
- Registered outputs (1-cycle latency): rb_rollback_strand[s] = winner exists; pc/lane/retry taken from the winner; pc/lane hold their last value when no strobe.
- Per-strand FSM, RUN/HOLD/SUSP:
  - RUN → SUSP on a winner with rq_suspend.
  - RUN → HOLD on any other winner; counter loads HOLDOFF_CYCLES.
  - HOLD decrements each cycle and → RUN when the counter is 1 and no new winner arrives.
  - A new winner in HOLD reloads the counter, or → SUSP if it suspends.
  - SUSP → RUN on wake_strand[s]. A winner in SUSP is still strobed but the state stays SUSP.
  - wake_strand and a suspend winner in the same cycle: suspend wins.
- rb_strand_blocked[s] = state != RUN (registered).
- Retry counter (8 bits, per strand):
  - +1 on a winner with rq_retry, saturating at 255.
  - Cleared on a non-retry winner or on wake.
  - rb_livelock[s] sets when count reaches RETRY_LIMIT; cleared only by reset.
- Reset (reset==0 at a clk edge): all strands RUN; all registered outputs, counters and flags = 0. Reset wins over any concurrent request. A mid-holdoff or suspended strand returns to RUN.
- rq_strand ≥ NUM_STRANDS cannot occur (power-of-two strands).

Decomposition:
- Shared package rollback_pkg: strand_state_t enum {RUN,HOLD,SUSP}, rollback_req_t struct {valid,strand,pc,lane,retry,suspend}, SIW helper constant.
- One sub-module, strand_rollback_state: per-strand FSM, holdoff counter and retry counter, instantiated NUM_STRANDS times in a generate loop.
- Winner select and squash stay in the top level.

Test Plan:
- Source 0 requests strand 2, pc 0x100; stages 0 and 3 hold strand 2 → rb_squash=6'b000001. Next cycle rb_rollback_strand=4'b0100, pc[2]=0x100; blocked[2]=1 for exactly 2 cycles.
- Sources 0 and 1 both request strand 1 (pc 0x40 / 0x80) → rb_rollback_pc[1]=0x80; squash uses SOURCE_STAGE[1]=5.
- Source 1 requests strand 3 with suspend → blocked[3] stays 1 for 20 idle cycles. wake_strand[3] → blocked[3]=0 next cycle.
- Eight consecutive retry winners for strand 0 → rb_livelock[0]=1 after the 8th. A non-retry rollback clears the count but leaves livelock set.
- Winner for strand 1 arrives on HOLD cycle 2 → counter reloads; blocked[1] stays 1 for 2 more cycles.
- reset=0 while strand 2 is in SUSP with count 5 → all outputs 0 next cycle and strand 2 back to RUN.
